// File: rtl/integer_seq_alu.sv
// Clocked, handshaked integer ALU with registered result, carry and zero flags.
// Shifts run iteratively, moving up to SHIFT_STEP bit positions per cycle.

package integer_seq_alu_pkg;
  localparam int unsigned ALU_OP_W = 6;

  localparam logic [ALU_OP_W-1:0] ALU_OP_PLUS            = 6'h00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB             = 6'h01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_LEFT      = 6'h02;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_RIGHT     = 6'h03;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SHIFT_RIGHT_A   = 6'h04;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SET_LESS_THAN   = 6'h05;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SET_LESS_THAN_U = 6'h06;
  localparam logic [ALU_OP_W-1:0] ALU_OP_AND             = 6'h07;
  localparam logic [ALU_OP_W-1:0] ALU_OP_OR              = 6'h08;
  localparam logic [ALU_OP_W-1:0] ALU_OP_XOR             = 6'h09;
endpackage

module integer_seq_alu
  import integer_seq_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  carry,
  output logic                  zero
);

  localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);
  // One extra bit so SHIFT_STEP == DATA_WIDTH is representable in step arithmetic.
  localparam int unsigned CNT_W   = SHAMT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_WIDTH-1:0] work;
  logic [SHAMT_W-1:0]    remaining;
  logic                  sh_left;
  logic                  sh_arith;

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] op_out;
  logic                  op_carry;
  logic                  is_shift;

  logic [CNT_W-1:0]      step_amt;
  logic [CNT_W-1:0]      rem_next;
  logic [DATA_WIDTH:0]   left_ext;
  logic [DATA_WIDTH:0]   right_ext;
  logic [DATA_WIDTH-1:0] shift_res;
  logic                  shift_c;

  assign shamt = B[SHAMT_W-1:0];

  // Single-cycle result for every opcode; shifts only supply the shamt==0 case here.
  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    op_out   = '0;
    op_carry = 1'b0;
    is_shift = 1'b0;
    case (alu_op)
      ALU_OP_PLUS: begin
        op_out   = sum[DATA_WIDTH-1:0];
        op_carry = sum[DATA_WIDTH];
      end
      ALU_OP_SUB: begin
        op_out   = diff[DATA_WIDTH-1:0];
        op_carry = diff[DATA_WIDTH];
      end
      ALU_OP_SHIFT_LEFT, ALU_OP_SHIFT_RIGHT, ALU_OP_SHIFT_RIGHT_A: begin
        is_shift = 1'b1;
        op_out   = A;
      end
      ALU_OP_SET_LESS_THAN:   op_out = DATA_WIDTH'($signed(A) < $signed(B));
      ALU_OP_SET_LESS_THAN_U: op_out = DATA_WIDTH'(A < B);
      ALU_OP_AND:             op_out = A & B;
      ALU_OP_OR:              op_out = A | B;
      ALU_OP_XOR:             op_out = A ^ B;
      default: ;
    endcase
  end

  // One iterative shift step; the extension bit catches the last bit shifted out.
  always_comb begin
    step_amt = ({1'b0, remaining} > CNT_W'(SHIFT_STEP)) ? CNT_W'(SHIFT_STEP)
                                                        : {1'b0, remaining};
    rem_next = {1'b0, remaining} - step_amt;
    left_ext = {1'b0, work} << step_amt;
    if (sh_arith) begin
      right_ext = $signed({work, 1'b0}) >>> step_amt;
    end else begin
      right_ext = {work, 1'b0} >> step_amt;
    end
    shift_res = sh_left ? left_ext[DATA_WIDTH-1:0] : right_ext[DATA_WIDTH:1];
    shift_c   = sh_left ? left_ext[DATA_WIDTH] : right_ext[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      work      <= '0;
      remaining <= '0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (is_shift && (shamt != '0)) begin
              work      <= A;
              remaining <= shamt;
              sh_left   <= (alu_op == ALU_OP_SHIFT_LEFT);
              sh_arith  <= (alu_op == ALU_OP_SHIFT_RIGHT_A);
              state     <= SHIFT;
            end else begin
              out       <= op_out;
              carry     <= op_carry;
              zero      <= (op_out == '0);
              out_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SHIFT: begin
          work      <= shift_res;
          remaining <= SHAMT_W'(rem_next);
          if (rem_next == '0) begin
            out       <= shift_res;
            carry     <= shift_c;
            zero      <= (shift_res == '0);
            out_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_integer_seq_alu.sv
// Self-checking bench for integer_seq_alu: directed vectors, reset abort, and
// random operations checked against a plain-arithmetic reference model.

module tb_integer_seq_alu;
  import integer_seq_alu_pkg::*;

  localparam int W    = 32;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    alu_op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          carry;
  logic          zero;

  int errors = 0;
  int checks = 0;

  integer_seq_alu #(.DATA_WIDTH(W), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_c;
    int           exp_lat;
    int           hold;
  } vec_t;

  vec_t vecs[13];
  logic [5:0] ops[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the opcode definitions.
  function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output int lat);
    int sh;
    sh  = int'(b[4:0]);
    r   = '0;
    c   = 1'b0;
    lat = 1;
    case (op)
      ALU_OP_PLUS: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > 33'hFFFF_FFFF; end
      ALU_OP_SUB:  begin r = a - b; c = (a < b); end
      ALU_OP_SHIFT_LEFT: begin
        r = a << sh;
        if (sh > 0) begin c = a[W - sh]; lat = 1 + (sh + STEP - 1) / STEP; end
      end
      ALU_OP_SHIFT_RIGHT: begin
        r = a >> sh;
        if (sh > 0) begin c = a[sh - 1]; lat = 1 + (sh + STEP - 1) / STEP; end
      end
      ALU_OP_SHIFT_RIGHT_A: begin
        r = $signed(a) >>> sh;
        if (sh > 0) begin c = a[sh - 1]; lat = 1 + (sh + STEP - 1) / STEP; end
      end
      ALU_OP_SET_LESS_THAN:   r = ($signed(a) < $signed(b)) ? 1 : 0;
      ALU_OP_SET_LESS_THAN_U: r = (a < b) ? 1 : 0;
      ALU_OP_AND:             r = a & b;
      ALU_OP_OR:              r = a | b;
      ALU_OP_XOR:             r = a ^ b;
      default: ;
    endcase
  endfunction

  task automatic do_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_out, input logic exp_c, input int exp_lat,
                       input int hold, input string tag);
    int waitc = 0;
    int lat;
    logic busy_ok = 1'b1;
    logic stable = 1'b1;
    logic [W-1:0] held;
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " in_ready idle"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    alu_op   = op;
    A        = a;
    B        = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    alu_op   = 6'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " out"}, 64'(out), 64'(exp_out));
    check({tag, " carry"}, 64'(carry), 64'(exp_c));
    check({tag, " zero"}, 64'(zero), 64'(exp_out == '0));
    check({tag, " busy in_ready"}, 64'(busy_ok && !in_ready), 64'(1));
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out !== held || !out_valid || in_ready) stable = 1'b0;
    end
    if (hold > 0) check({tag, " held stable"}, 64'(stable), 64'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " drained"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  initial begin
    logic [W-1:0] r;
    logic c;
    int lat;
    logic stale;

    ops = '{ALU_OP_PLUS, ALU_OP_SUB, ALU_OP_SHIFT_LEFT, ALU_OP_SHIFT_RIGHT,
            ALU_OP_SHIFT_RIGHT_A, ALU_OP_SET_LESS_THAN, ALU_OP_SET_LESS_THAN_U,
            ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR};

    vecs[0]  = '{ALU_OP_PLUS,            32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1, 0};
    vecs[1]  = '{ALU_OP_SUB,             32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1, 0};
    vecs[2]  = '{ALU_OP_SET_LESS_THAN,   32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1, 0};
    vecs[3]  = '{ALU_OP_SET_LESS_THAN_U, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0};
    vecs[4]  = '{ALU_OP_SHIFT_LEFT,      32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1, 2, 0};
    vecs[5]  = '{ALU_OP_SHIFT_LEFT,      32'h8000_0001, 32'h0000_0021, 32'h0000_0002, 1'b1, 2, 0};
    vecs[6]  = '{ALU_OP_SHIFT_RIGHT_A,   32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 9, 0};
    vecs[7]  = '{ALU_OP_XOR,             32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1, 5};
    vecs[8]  = '{6'h3F,                  32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1'b0, 1, 0};
    vecs[9]  = '{ALU_OP_SHIFT_RIGHT,     32'h0000_1234, 32'h0000_0020, 32'h0000_1234, 1'b0, 1, 0};
    vecs[10] = '{ALU_OP_SHIFT_RIGHT,     32'h8000_0008, 32'd4,         32'h0800_0000, 1'b1, 2, 2};
    vecs[11] = '{ALU_OP_AND,             32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1, 0};
    vecs[12] = '{ALU_OP_OR,              32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 1'b0, 1, 1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_op    = '0;
    A         = '0;
    B         = '0;
    repeat (2) @(negedge clk);
    check("reset state", 64'({in_ready, out_valid, carry, zero}), 64'(4'b0001));
    check("reset out", 64'(out), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_c,
            vecs[i].exp_lat, vecs[i].hold, $sformatf("vec%0d", i));

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      logic [W-1:0] a, b;
      int k;
      k  = $urandom_range(0, 10);
      op = (k == 10) ? 6'($urandom_range(10, 63)) : ops[k];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(0, 3));
      model(op, a, b, r, c, lat);
      do_op(op, a, b, r, c, lat, $urandom_range(0, 2), $sformatf("rnd%0d op%0h", n, op));
    end

    // Reset during the third shift cycle must abort with no late response.
    do_op(ALU_OP_PLUS, 32'd7, 32'd1, 32'd8, 1'b0, 1, 0, "pre-abort");
    in_valid = 1'b1;
    alu_op   = ALU_OP_SHIFT_RIGHT;
    A        = 32'hDEAD_BEEF;
    B        = 32'd20;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort flags", 64'({in_ready, out_valid, carry, zero}), 64'(4'b0001));
    check("abort out", 64'(out), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    stale = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no stale response", 64'(stale), 64'(0));
    do_op(ALU_OP_PLUS, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0, "post-abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integer_seq_alu.md
Name: integer_seq_alu

Overview:
- Clocked, handshaked successor to the combinational integer ALU.
- Executes the same `ALU_OP_*` opcode set with registered results and a valid/ready interface, plus a zero flag.
- Shifts run on an iterative shifter that moves SHIFT_STEP bits per cycle instead of a full barrel shifter.
- Sits between the core's operand-fetch stage and writeback; supports back-pressure from writeback.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be ≥ 2.
- SHIFT_STEP, 4, max bit positions shifted per SHIFT cycle; range 1..DATA_WIDTH.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept an operation.
- alu_op  input  6  opcode, encoded per the `ALU_OP_*` macros in the team opcode header.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B; shifts use B[SHAMT_W-1:0] only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  DATA_WIDTH  result.
- carry  output  1  carry/borrow/shifted-out bit.
- zero  output  1  out == 0.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=0 while reset is high, out_valid=0, out=0, carry=0, zero=1, shift counters=0.
- State machine:
  - IDLE: in_ready=1. On in_valid, the operation is accepted at the clock edge.
  - Non-shift op: result computed and registered on the accept edge; next state RESP.
  - Shift op with shamt>0: load working register; next state SHIFT.
  - Shift op with shamt=0: out=A, carry=0; next state RESP.
- SHIFT:
  - Each cycle shifts by min(SHIFT_STEP, remaining), then decrements remaining by that amount.
  - When remaining reaches 0 → RESP.
  - SHIFT cycles = ceil(shamt/SHIFT_STEP).
- RESP:
  - out_valid=1; out, carry and zero are held stable.
  - On out_ready, go to IDLE at the next edge.
  - in_ready=0 in SHIFT and RESP; there is no overlap or pipelining.
- Latency from accept edge to out_valid:
  - Non-shift ops and shamt=0: 1 cycle.
  - Other shifts: 1 + ceil(shamt/SHIFT_STEP) cycles.
- Arithmetic:
  - PLUS: out = A+B mod 2^W; carry = unsigned carry-out.
  - SUB: out = A−B; carry = bit W of {0,A}−B, i.e. borrow, 1 when A<B unsigned.
  - SHIFT_LEFT: logical left shift; carry = A[W−shamt], the last bit shifted out.
  - SHIFT_RIGHT: logical right shift; carry = A[shamt−1].
  - SHIFT_RIGHT_A: arithmetic right shift, sign fill from A[W−1]; carry = A[shamt−1].
  - SET_LESS_THAN: out = {0…,signed A<B}. SET_LESS_THAN_U: out = {0…,unsigned A<B}. Both give carry=0.
  - AND/OR/XOR: bitwise; carry=0.
- Unknown opcode: accepted normally, out=0, carry=0, zero=1, latency 1.
- zero is registered together with out and always equals (out==0).
- Operands are captured at accept; A/B/alu_op changes after acceptance have no effect.
- Reset asserted mid-SHIFT or in RESP aborts the operation immediately. No out_valid pulse follows; the block returns to IDLE after reset deasserts.

Test Plan:
- PLUS A=0xFFFFFFFF, B=0x00000001 → out_valid 1 cycle after accept; out=0x00000000, carry=1, zero=1.
- SUB A=0, B=1 → out=0xFFFFFFFF, carry=1, zero=0. Also SLT A=0xFFFFFFFF, B=1 → out=1, while SLTU with the same operands → out=0.
- SHIFT_LEFT A=0x80000001, B=1, SHIFT_STEP=4 → out=0x00000002, carry=1, out_valid 2 cycles after accept. Also B=0x21 (shamt=1, upper bits ignored) → same result.
- SHIFT_RIGHT_A A=0x80000000, B=31, SHIFT_STEP=4 → out=0xFFFFFFFF, carry=0, out_valid 9 cycles after accept, in_ready=0 throughout.
- Back-pressure: hold out_ready=0 for 5 cycles after XOR A=0xF0F0F0F0, B=0xFFFFFFFF → out=0x0F0F0F0F held stable with out_valid=1, in_ready=0. Then out_ready=1 → IDLE and in_ready=1 the next cycle.
- Reset mid-shift: SHIFT_RIGHT B=20, assert reset on the 3rd SHIFT cycle → out_valid=0, out=0, zero=1 immediately, no stale response after release. The next PLUS 2+3 → out=5.
